// File: rtl/sum_disp_pkg.sv
// Shared types, segment constants and double-dabble helpers for the BCD display stage.
package sum_disp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      SHOW_H  = 3'd2,
      SHOW_T  = 3'd3,
      SHOW_O  = 3'd4,
      GAP     = 3'd5
   } state_t;

   localparam int unsigned BCD_W   = 12;
   localparam int unsigned BIN_W   = 8;
   localparam int unsigned SHIFT_W = BCD_W + BIN_W;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active high
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;

   // One shift-add-3 iteration over the {H,T,O,bin} shifter
   function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
      logic [SHIFT_W-1:0] a;
      a = s;
      for (int i = 0; i < 3; i++) begin
         if (a[BIN_W+4*i +: 4] >= 4'd5) begin
            a[BIN_W+4*i +: 4] = a[BIN_W+4*i +: 4] + 4'd3;
         end
      end
      return {a[SHIFT_W-2:0], 1'b0};
   endfunction

   // Leading-zero blanking: first non-zero digit, or the ones digit for zero
   function automatic state_t first_state(input logic [BCD_W-1:0] bcd);
      if (bcd[11:8] != 4'd0) begin
         return SHOW_H;
      end else if (bcd[7:4] != 4'd0) begin
         return SHOW_T;
      end
      return SHOW_O;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes blank the display.
module seg7_decode
   import sum_disp_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/sum_bcd_display.sv
// Converts an 8-bit sum to BCD (sequential double-dabble) and shows it digit by digit on one
// 7-segment display with leading-zero blanking, dp on the ones digit, and a repeating loop.
module sum_bcd_display
   import sum_disp_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 10_000_000,
   parameter int unsigned GAP_CYCLES   = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);

   localparam int unsigned MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

   state_t               r_state, w_state_nxt;
   logic [SHIFT_W-1:0]   r_shift, w_shift_nxt, w_step;
   logic [2:0]           r_iter, w_iter_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [6:0]           r_seg, w_seg_dec;
   logic                 r_dp;
   logic                 w_accept, w_show;
   logic [3:0]           w_digit;
   state_t               w_first;

   assign in_ready = (r_state != CONVERT);
   assign busy     = (r_state != IDLE);
   assign w_accept = in_valid && in_ready;
   assign w_step   = dabble_step(r_shift);
   assign w_show   = (r_state == SHOW_H) || (r_state == SHOW_T) || (r_state == SHOW_O);
   // On the last iteration the result only exists in w_step; afterwards r_shift holds it
   assign w_first  = first_state((r_state == CONVERT) ? w_step[SHIFT_W-1:BIN_W]
                                                      : r_shift[SHIFT_W-1:BIN_W]);

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_iter_nxt  = r_iter;
      w_cnt_nxt   = r_cnt;
      if (w_accept) begin
         w_state_nxt = CONVERT;
         w_shift_nxt = {{BCD_W{1'b0}}, in_data};
         w_iter_nxt  = 3'd0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            CONVERT: begin
               w_shift_nxt = w_step;
               w_iter_nxt  = r_iter + 3'd1;
               if (r_iter == 3'd7) begin
                  w_state_nxt = w_first;
                  w_cnt_nxt   = DWELL_LD;
               end
            end
            SHOW_H, SHOW_T, SHOW_O, GAP: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else begin
                  case (r_state)
                     SHOW_H:  w_state_nxt = SHOW_T;
                     SHOW_T:  w_state_nxt = SHOW_O;
                     SHOW_O:  w_state_nxt = GAP;
                     default: w_state_nxt = w_first;
                  endcase
                  w_cnt_nxt = (r_state == SHOW_O) ? GAP_LD : DWELL_LD;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_digit = 4'd0;
      case (r_state)
         SHOW_H:  w_digit = r_shift[19:16];
         SHOW_T:  w_digit = r_shift[15:12];
         SHOW_O:  w_digit = r_shift[11:8];
         default: w_digit = 4'd0;
      endcase
   end

   seg7_decode u_seg7_decode (
      .i_digit (w_digit),
      .o_seg   (w_seg_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_iter  <= 3'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_iter  <= w_iter_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs follow the state by one clock, except that a new accept blanks them immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_OFF;
         r_dp  <= 1'b0;
      end else if (w_accept || !w_show) begin
         r_seg <= SEG_OFF;
         r_dp  <= 1'b0;
      end else begin
         r_seg <= w_seg_dec;
         r_dp  <= (r_state == SHOW_O);
      end
   end

   assign seg = r_seg;
   assign dp  = r_dp;

endmodule
